hls_deadlock_reporter: RTL and testbench
========================================

HLS_DEADLOCK_REPORTER -- requirements
Module: hls_deadlock_reporter

Interface
REQ-001 SHALL have parameter NUM_PROC, default 2: number of dataflow processes observed.
REQ-002 SHALL have parameter THRESH, default 1024: consecutive asserted-block cycles needed to declare deadlock; legal range 1..65535.
REQ-003 SHALL have parameter TS_W, default 32: width of the cycle timestamp.
REQ-004 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port block  in  1  registered block flag from the per-instance deadlock monitor.
REQ-007 SHALL have port axis_block_sigs  in  NUM_PROC  per-process AXIS-blocked flags, same cycle as the monitor inputs.
REQ-008 SHALL have port inst_chan_block_sigs  in  NUM_PROC  per-process internal-channel-blocked flags.
REQ-009 SHALL have port inst_idle_sigs  in  NUM_PROC  per-process idle flags.
REQ-010 SHALL have port clear  in  1  software acknowledge; rearms the reporter.
REQ-011 SHALL have port deadlock  out  1  sticky deadlock-declared flag.
REQ-012 SHALL have port rpt_valid  out  1  report record available.
REQ-013 SHALL have port rpt_ready  in  1  consumer accepts the report.
REQ-014 SHALL have ports rpt_axis, rpt_chan, rpt_idle  out  NUM_PROC each  snapshot of the three input vectors.
REQ-015 SHALL have port rpt_cycle  out  TS_W  timestamp of deadlock declaration.
REQ-016 SHALL have port glitch_cnt  out  16  count of block episodes that cleared before THRESH.

Function
REQ-017 SHALL implement FSM states MONITOR, SUSPECT, REPORT, HOLD.
REQ-018 SHALL keep free-running cycle counter cyc (TS_W bits) incrementing every cycle, saturating at all-ones.
REQ-019 In MONITOR, block=1 SHALL move to SUSPECT with persistence count pcnt=1; otherwise pcnt=0.
REQ-020 In SUSPECT, block=1 SHALL increment pcnt; when pcnt=THRESH the FSM SHALL move to REPORT in the same cycle pcnt would reach THRESH.
REQ-021 On MONITOR->SUSPECT and on every SUSPECT cycle, the snapshot registers SHALL load axis_block_sigs, inst_chan_block_sigs, inst_idle_sigs and cyc, so the record holds values from the THRESH-th blocked cycle.
REQ-022 In SUSPECT, block=0 SHALL return to MONITOR, clear pcnt and increment glitch_cnt (saturating at 16'hFFFF).
REQ-023 With THRESH=1, the first block=1 cycle SHALL move MONITOR directly to REPORT.
REQ-024 deadlock SHALL be 1 in REPORT and HOLD, 0 in MONITOR and SUSPECT; registered output.
REQ-025 rpt_valid SHALL be 1 exactly in REPORT; rpt_* SHALL be stable while rpt_valid=1 and rpt_ready=0.
REQ-026 In REPORT, rpt_ready=1 SHALL complete transfer and move to HOLD next cycle; rpt_ready before rpt_valid SHALL have no effect.
REQ-027 In HOLD, block input SHALL be ignored; snapshot retained on rpt_* with rpt_valid=0.
REQ-028 clear=1 in any state SHALL move to MONITOR next cycle, clearing pcnt and deadlock, aborting any pending report; glitch_cnt and cyc unaffected.
REQ-029 clear and rpt_ready both 1 in REPORT SHALL count as accepted, then go to MONITOR.
REQ-030 clear=1 with block=1 SHALL take priority: next state MONITOR, pcnt=0.

Reset
REQ-031 reset SHALL force state MONITOR, deadlock=0, rpt_valid=0, rpt_axis=rpt_chan=rpt_idle=0, rpt_cycle=0, cyc=0, pcnt=0, glitch_cnt=0.
REQ-032 reset SHALL override clear, block and rpt_ready, including mid-REPORT.

Structure
REQ-033 FSM state enum and default THRESH/TS_W constants SHALL live in the shared deadlock-debug package.
REQ-034 The saturating counter SHALL be sub-module dlk_sat_counter (parameter width, inc, clr), used for cyc, pcnt and glitch_cnt.

Verification
REQ-035 THRESH=4, block high 4 cycles from cyc=10 -> deadlock=1 and rpt_valid=1 at cyc=14, rpt_cycle=13.
REQ-036 THRESH=4, block high 3 cycles then low -> no deadlock, glitch_cnt=1; repeat twice -> glitch_cnt=3.
REQ-037 rpt_ready held low 20 cycles after declaration while inputs toggle -> rpt_* unchanged; rpt_ready pulse -> rpt_valid=0 next cycle, deadlock stays 1.
REQ-038 clear during REPORT -> rpt_valid=0, deadlock=0 next cycle; new 4-cycle block -> second report with new rpt_cycle.
REQ-039 reset asserted in REPORT with rpt_ready=1 -> all outputs zero next cycle, no handshake completed.
REQ-040 THRESH=1, axis_block_sigs=2'b01, idle=2'b10 with block=1 -> rpt_axis=2'b01, rpt_idle=2'b10, rpt_valid=1 next cycle.

Source files
------------

// File: rtl/hls_deadlock_reporter_pkg.sv
// Shared deadlock-debug definitions: reporter FSM states and default sizing.
package hls_deadlock_reporter_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    SUSPECT = 2'd1,
    REPORT  = 2'd2,
    HOLD    = 2'd3
  } dlk_state_e;

  localparam int DLK_THRESH_DEFAULT = 1024;
  localparam int DLK_TS_W_DEFAULT   = 32;
  localparam int DLK_PCNT_W         = 16;
  localparam int DLK_GLITCH_W       = 16;

endpackage

// File: rtl/hls_deadlock_reporter_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module dlk_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hls_deadlock_reporter.sv
// Watches the dataflow deadlock monitor's block flag, declares deadlock after
// THRESH consecutive blocked cycles and offers one snapshot record to software.
module hls_deadlock_reporter
  import hls_deadlock_reporter_pkg::*;
#(
  parameter int NUM_PROC = 2,
  parameter int THRESH   = DLK_THRESH_DEFAULT,
  parameter int TS_W     = DLK_TS_W_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    block,
  input  logic [NUM_PROC-1:0]     axis_block_sigs,
  input  logic [NUM_PROC-1:0]     inst_chan_block_sigs,
  input  logic [NUM_PROC-1:0]     inst_idle_sigs,
  input  logic                    clear,
  output logic                    deadlock,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [NUM_PROC-1:0]     rpt_axis,
  output logic [NUM_PROC-1:0]     rpt_chan,
  output logic [NUM_PROC-1:0]     rpt_idle,
  output logic [TS_W-1:0]         rpt_cycle,
  output logic [DLK_GLITCH_W-1:0] glitch_cnt
);

  // pcnt counts blocked cycles already seen, so reaching THRESH-1 plus a
  // blocked cycle now is the THRESH-th one (in MONITOR pcnt is 0, covering THRESH=1).
  localparam logic [DLK_PCNT_W-1:0] PCNT_LAST = DLK_PCNT_W'(THRESH - 1);

  dlk_state_e              r_state;
  dlk_state_e              w_state_next;
  logic                    r_deadlock;
  logic                    r_rpt_valid;
  logic [NUM_PROC-1:0]     r_axis;
  logic [NUM_PROC-1:0]     r_chan;
  logic [NUM_PROC-1:0]     r_idle;
  logic [TS_W-1:0]         r_rpt_cycle;
  logic [TS_W-1:0]         w_cyc;
  logic [DLK_PCNT_W-1:0]   w_pcnt;
  logic                    w_pcnt_hit;
  logic                    w_snap_load;
  logic                    w_pcnt_inc;
  logic                    w_glitch_inc;

  assign w_pcnt_hit = (w_pcnt == PCNT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_snap_load  = 1'b0;
    w_glitch_inc = 1'b0;
    if (clear) begin
      w_state_next = MONITOR;
    end else begin
      case (r_state)
        MONITOR: begin
          if (block) begin
            w_snap_load  = 1'b1;
            w_state_next = w_pcnt_hit ? REPORT : SUSPECT;
          end
        end
        SUSPECT: begin
          w_snap_load = 1'b1;
          if (!block) begin
            w_state_next = MONITOR;
            w_glitch_inc = 1'b1;
          end else if (w_pcnt_hit) begin
            w_state_next = REPORT;
          end
        end
        REPORT: begin
          if (rpt_ready) w_state_next = HOLD;
        end
        HOLD: begin
          w_state_next = HOLD;
        end
        default: w_state_next = MONITOR;
      endcase
    end
  end

  assign w_pcnt_inc = (w_state_next == SUSPECT);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= MONITOR;
      r_deadlock  <= 1'b0;
      r_rpt_valid <= 1'b0;
      r_axis      <= '0;
      r_chan      <= '0;
      r_idle      <= '0;
      r_rpt_cycle <= '0;
    end else begin
      r_state     <= w_state_next;
      r_deadlock  <= (w_state_next == REPORT) || (w_state_next == HOLD);
      r_rpt_valid <= (w_state_next == REPORT);
      if (w_snap_load) begin
        r_axis      <= axis_block_sigs;
        r_chan      <= inst_chan_block_sigs;
        r_idle      <= inst_idle_sigs;
        r_rpt_cycle <= w_cyc;
      end
    end
  end

  dlk_sat_counter #(.WIDTH(TS_W)) u_cyc (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .clr   (1'b0),
    .count (w_cyc)
  );

  dlk_sat_counter #(.WIDTH(DLK_PCNT_W)) u_pcnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_pcnt_inc),
    .clr   (!w_pcnt_inc),
    .count (w_pcnt)
  );

  dlk_sat_counter #(.WIDTH(DLK_GLITCH_W)) u_glitch (
    .clock (clock),
    .reset (reset),
    .inc   (w_glitch_inc),
    .clr   (1'b0),
    .count (glitch_cnt)
  );

  assign deadlock  = r_deadlock;
  assign rpt_valid = r_rpt_valid;
  assign rpt_axis  = r_axis;
  assign rpt_chan  = r_chan;
  assign rpt_idle  = r_idle;
  assign rpt_cycle = r_rpt_cycle;

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// run-length reference model of the deadlock reporter.
module tb_hls_deadlock_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  axis, chan, idle;
  logic        block_a, clear_a, ready_a;
  logic        block_b, clear_b, ready_b;

  logic        dl_a, val_a, dl_b, val_b;
  logic [1:0]  rax_a, rch_a, rid_a, rax_b, rch_b, rid_b;
  logic [31:0] rcy_a, rcy_b;
  logic [15:0] gl_a, gl_b;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state for instance A (THRESH=4)
  int unsigned m_cyc;
  int unsigned m_scyc;
  int          m_run;
  int          m_glitch;
  bit          m_decl, m_acc;
  logic [1:0]  m_ax, m_ch, m_id;

  logic [31:0] first_rcy;

  always #5 clk = ~clk;

  hls_deadlock_reporter #(.NUM_PROC(2), .THRESH(4), .TS_W(32)) dut_a (
    .clock(clk), .reset(rst), .block(block_a),
    .axis_block_sigs(axis), .inst_chan_block_sigs(chan), .inst_idle_sigs(idle),
    .clear(clear_a), .deadlock(dl_a), .rpt_valid(val_a), .rpt_ready(ready_a),
    .rpt_axis(rax_a), .rpt_chan(rch_a), .rpt_idle(rid_a),
    .rpt_cycle(rcy_a), .glitch_cnt(gl_a)
  );

  hls_deadlock_reporter #(.NUM_PROC(2), .THRESH(1), .TS_W(32)) dut_b (
    .clock(clk), .reset(rst), .block(block_b),
    .axis_block_sigs(axis), .inst_chan_block_sigs(chan), .inst_idle_sigs(idle),
    .clear(clear_b), .deadlock(dl_b), .rpt_valid(val_b), .rpt_ready(ready_b),
    .rpt_axis(rax_b), .rpt_chan(rch_b), .rpt_idle(rid_b),
    .rpt_cycle(rcy_b), .glitch_cnt(gl_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: deadlock is declared after THRESH consecutive blocked cycles since
  // the last rearm; an interrupted run is a glitch; the record is the inputs
  // of the most recent blocked cycle before declaration.
  task automatic model_step();
    int unsigned now;
    if (rst) begin
      m_cyc = 0; m_scyc = 0; m_run = 0; m_glitch = 0;
      m_decl = 0; m_acc = 0; m_ax = 0; m_ch = 0; m_id = 0;
    end else begin
      now = m_cyc;
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (clear_a) begin
        m_decl = 0; m_acc = 0; m_run = 0;
      end else if (!m_decl) begin
        if (block_a) begin
          m_run++;
          m_ax = axis; m_ch = chan; m_id = idle; m_scyc = now;
          if (m_run == 4) begin
            m_decl = 1; m_acc = 0; m_run = 0;
          end
        end else begin
          if (m_run > 0 && m_glitch < 65535) m_glitch++;
          m_run = 0;
        end
      end else if (!m_acc && ready_a) begin
        m_acc = 1;
      end
    end
  endtask

  task automatic check_a();
    chk("deadlock", dl_a, m_decl);
    chk("rpt_valid", val_a, m_decl && !m_acc);
    chk("glitch_cnt", gl_a, m_glitch);
    if (m_decl) begin
      chk("rpt_axis", rax_a, m_ax);
      chk("rpt_chan", rch_a, m_ch);
      chk("rpt_idle", rid_a, m_id);
      chk("rpt_cycle", rcy_a, m_scyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_a();
  endtask

  task automatic block_run(input int n);
    block_a = 1'b1;
    repeat (n) tick();
    block_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1; axis = '0; chan = '0; idle = '0;
    block_a = 0; clear_a = 0; ready_a = 0;
    block_b = 0; clear_b = 0; ready_b = 0;
    repeat (3) tick();
    chk("rst_b_valid", val_b, 0);
    chk("rst_b_deadlock", dl_b, 0);
    chk("rst_a_rpt_cycle", rcy_a, 0);
    rst = 1'b0;

    // block from cyc=10 for four cycles
    for (int i = 0; i < 20 && m_cyc != 10; i++) tick();
    axis = 2'b01; chan = 2'b10; idle = 2'b00;
    block_run(4);
    chk("req035_deadlock", dl_a, 1);
    chk("req035_valid", val_a, 1);
    chk("req035_rpt_cycle", rcy_a, 13);
    chk("req035_rpt_axis", rax_a, 2'b01);

    // report held while consumer stalls and inputs churn
    for (int i = 0; i < 20; i++) begin
      axis = 2'($urandom_range(0, 3)); chan = 2'($urandom_range(0, 3));
      idle = 2'($urandom_range(0, 3)); block_a = 1'($urandom_range(0, 1));
      tick();
      chk("req037_hold_axis", rax_a, 2'b01);
      chk("req037_hold_chan", rch_a, 2'b10);
      chk("req037_hold_cycle", rcy_a, 13);
    end
    block_a = 0; ready_a = 1; tick(); ready_a = 0;
    chk("req037_valid_drop", val_a, 0);
    chk("req037_deadlock_kept", dl_a, 1);
    block_a = 1; repeat (3) tick(); block_a = 0;
    chk("hold_ignores_block", val_a, 0);
    clear_a = 1; tick(); clear_a = 0;
    chk("clear_from_hold", dl_a, 0);

    // short episodes are glitches
    block_run(3); tick();
    chk("req036_glitch1", gl_a, 1);
    block_run(3); tick();
    block_run(3); tick();
    chk("req036_glitch3", gl_a, 3);
    chk("req036_no_deadlock", dl_a, 0);

    // clear aborts a pending report, then a fresh report is produced
    block_run(4);
    first_rcy = rcy_a;
    clear_a = 1; tick(); clear_a = 0;
    chk("req038_valid", val_a, 0);
    chk("req038_deadlock", dl_a, 0);
    block_run(4);
    chk("req038_second_valid", val_a, 1);
    chk("req038_new_cycle", rcy_a != first_rcy, 1);

    // clear together with ready in REPORT
    clear_a = 1; ready_a = 1; tick(); clear_a = 0; ready_a = 0;
    chk("req029_deadlock", dl_a, 0);

    // clear with block restarts the persistence count
    block_run(2);
    block_a = 1; clear_a = 1; tick(); clear_a = 0;
    repeat (3) tick();
    chk("req030_not_yet", dl_a, 0);
    tick(); block_a = 0;
    chk("req030_declared", dl_a, 1);

    // reset wins over ready in REPORT
    ready_a = 1; rst = 1; tick(); rst = 0; ready_a = 0;
    chk("req039_deadlock", dl_a, 0);
    chk("req039_valid", val_a, 0);
    chk("req039_axis", rax_a, 0);
    chk("req039_chan", rch_a, 0);
    chk("req039_idle", rid_a, 0);
    chk("req039_cycle", rcy_a, 0);
    tick();

    // THRESH=1 instance declares on the first blocked cycle
    axis = 2'b01; chan = 2'b00; idle = 2'b10; block_b = 1;
    tick(); block_b = 0;
    chk("req040_valid", val_b, 1);
    chk("req040_deadlock", dl_b, 1);
    chk("req040_axis", rax_b, 2'b01);
    chk("req040_idle", rid_b, 2'b10);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      axis    = 2'($urandom_range(0, 3));
      chan    = 2'($urandom_range(0, 3));
      idle    = 2'($urandom_range(0, 3));
      block_a = ($urandom_range(0, 9) < 7);
      ready_a = ($urandom_range(0, 3) == 0);
      clear_a = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
